mem_initiator: RTL and testbench

MEM_INITIATOR -- requirements
Module: mem_initiator

---
 rtl/mem_if_pkg.sv | 17 +
 rtl/mem_pattern_gen.sv | 23 ++
 rtl/mem_initiator.sv | 170 +++++++++++++++++
 tb/tb_mem_initiator.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types for the memory sweep initiator: FSM state and write/read phase encoding.
package mem_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Phase value doubles as the wr_rd request bit.
    typedef enum logic {
        PH_READ  = 1'b0,
        PH_WRITE = 1'b1
    } phase_t;

endpackage

// File: rtl/mem_pattern_gen.sv
// Test pattern for one location: seed XOR address, address zero-extended or truncated to WIDTH.
module mem_pattern_gen #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic [WIDTH-1:0]      seed,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      pattern
);

    logic [WIDTH-1:0] addr_ext;

    generate
        if (ADDR_WIDTH >= WIDTH) begin : g_trunc
            assign addr_ext = addr[WIDTH-1:0];
        end else begin : g_ext
            assign addr_ext = {{(WIDTH-ADDR_WIDTH){1'b0}}, addr};
        end
    endgenerate

    assign pattern = seed ^ addr_ext;

endmodule

// File: rtl/mem_initiator.sv
// Write/read-back memory sweep initiator: writes seed^addr to every location, then reads back and checks.
// Optional macro MEM_INITIATOR_TIMEOUT_EN bounds each wait for ready to TIMEOUT cycles.
module mem_initiator
    import mem_if_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      seed,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr
);

    state_t                state_reg, state_next;
    phase_t                phase_reg, phase_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [WIDTH-1:0]      seed_reg, seed_next;
    logic                  valid_reg, valid_next;
    logic [ADDR_WIDTH:0]   err_reg, err_next;
    logic [ADDR_WIDTH-1:0] ffa_reg, ffa_next;
    logic [WIDTH-1:0]      pattern;
    logic                  timeout_flag;

    // One generator serves both the write data and the read-back expectation.
    mem_pattern_gen #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pattern (
        .seed    (seed_reg),
        .addr    (addr_reg),
        .pattern (pattern)
    );

`ifdef MEM_INITIATOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic          timeout_reg, timeout_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            tcnt_reg    <= tcnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout_flag = timeout_reg;
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            phase_reg <= PH_READ;
            addr_reg  <= '0;
            seed_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= '0;
            ffa_reg   <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            addr_reg  <= addr_next;
            seed_reg  <= seed_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
            ffa_reg   <= ffa_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        addr_next  = addr_reg;
        seed_next  = seed_reg;
        valid_next = 1'b0;
        err_next   = err_reg;
        ffa_next   = ffa_reg;
`ifdef MEM_INITIATOR_TIMEOUT_EN
        tcnt_next    = tcnt_reg;
        timeout_next = timeout_reg;
`endif
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    seed_next  = seed;
                    err_next   = '0;
                    ffa_next   = '0;
                    addr_next  = '0;
                    phase_next = PH_WRITE;
                    valid_next = 1'b1;
                    state_next = ST_REQ;
`ifdef MEM_INITIATOR_TIMEOUT_EN
                    timeout_next = 1'b0;
`endif
                end
            end
            ST_REQ: begin
                state_next = ST_WAIT;
`ifdef MEM_INITIATOR_TIMEOUT_EN
                tcnt_next = '0;
`endif
            end
            ST_WAIT: begin
                if (ready) begin
                    if (phase_reg == PH_READ && rdata != pattern) begin
                        if (err_reg < (ADDR_WIDTH+1)'(DEPTH))
                            err_next = err_reg + 1'b1;
                        if (err_reg == '0)
                            ffa_next = addr_reg;
                    end
                    if (addr_reg == ADDR_WIDTH'(DEPTH - 1)) begin
                        if (phase_reg == PH_WRITE) begin
                            addr_next  = '0;
                            phase_next = PH_READ;
                            valid_next = 1'b1;
                            state_next = ST_REQ;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        addr_next  = addr_reg + 1'b1;
                        valid_next = 1'b1;
                        state_next = ST_REQ;
                    end
                end
`ifdef MEM_INITIATOR_TIMEOUT_EN
                // Counts WAIT cycles without ready; the TIMEOUT-th one gives up.
                else if (tcnt_reg == TW'(TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    state_next   = ST_DONE;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign valid           = valid_reg;
    assign wr_rd           = (phase_reg == PH_WRITE);
    assign addr            = addr_reg;
    assign wdata           = pattern;
    assign busy            = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
    assign done            = (state_reg == ST_DONE);
    assign pass            = done && (err_reg == '0) && !timeout_flag;
    assign timeout         = timeout_flag;
    assign err_count       = err_reg;
    assign first_fail_addr = ffa_reg;

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: behavioural responder with fault masks plus a sweep-level reference model.
module tb_mem_initiator;

    localparam int D  = 16;
    localparam int W  = 8;
    localparam int AW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  seed;
    logic          valid;
    logic          wr_rd;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic          ready;
    logic          busy, done, pass, timeout;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_fail_addr;

    int vectors     = 0;
    int miscompares = 0;

    mem_initiator #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_fail_addr(first_fail_addr)
    );

    always #5 clk = ~clk;

    // Responder: stores writes, returns stored data with injected faults, ready one cycle after valid.
    logic [W-1:0] mem      [D];
    logic [W-1:0] xor_mask [D];
    logic [W-1:0] and_mask [D];
    bit           ready_en = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= valid & ready_en;
            if (valid && wr_rd)  mem[addr] <= wdata;
            if (valid && !wr_rd) rdata <= (mem[addr] & and_mask[addr]) ^ xor_mask[addr];
        end
    end

    int            q_edge  [$];
    logic [AW-1:0] q_addr  [$];
    logic          q_wr    [$];
    logic [W-1:0]  q_wdata [$];
    int            done_edge;

    task automatic clear_faults();
        for (int a = 0; a < D; a++) begin
            xor_mask[a] = '0;
            and_mask[a] = '1;
        end
    endtask

    // Expected read-back outcome, assuming the pattern was written correctly.
    task automatic model_sweep(input logic [W-1:0] s, output int errs, output int first);
        logic [W-1:0] exp_v, got_v;
        errs  = 0;
        first = 0;
        for (int a = 0; a < D; a++) begin
            exp_v = s ^ W'(a);
            got_v = (exp_v & and_mask[a]) ^ xor_mask[a];
            if (got_v != exp_v) begin
                if (errs == 0) first = a;
                errs++;
            end
        end
        if (errs > D) errs = D;
    endtask

    // Drives one start (edge 0), logs every request with its edge index, stops at done or stop_edge.
    task automatic do_sweep(input logic [W-1:0] s, input int pulse_edge, input int stop_edge);
        q_edge.delete(); q_addr.delete(); q_wr.delete(); q_wdata.delete();
        done_edge = -1;
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        for (int e = 0; e < 4*D + 40; e++) begin
            @(posedge clk); #1;
            if (e == 0) start = 1'b0;
            if (valid) begin
                q_edge.push_back(e); q_addr.push_back(addr);
                q_wr.push_back(wr_rd); q_wdata.push_back(wdata);
            end
            if (e == pulse_edge - 1) begin start = 1'b1; seed = ~s; end
            if (e == pulse_edge)     begin start = 1'b0; seed = s;  end
            if (done) begin done_edge = e; break; end
            if (e == stop_edge) break;
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        rst = 1'b1; start = 1'b0; seed = '0;
        clear_faults();
        repeat (3) @(posedge clk);
        #1;
        got = 32'({valid, wr_rd, addr, wdata, busy, done, pass, timeout, err_count, first_fail_addr});
        vectors++;
        if (got !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: outputs=%h required 0", got);
        end
        $display("reset_state: outputs=%h", got);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_clean_sweep();
        logic [28:0] got, exp_t;
        clear_faults();
        do_sweep(8'hA5, -1, -1);
        vectors++;
        if (done_edge !== 4*D) begin
            miscompares++;
            $display("FAIL clean_done_edge: got %0d required %0d", done_edge, 4*D);
        end
        vectors++;
        if (q_edge.size() !== 2*D) begin
            miscompares++;
            $display("FAIL clean_req_count: got %0d required %0d", q_edge.size(), 2*D);
        end else begin
            for (int k = 0; k < 2*D; k++) begin
                got   = {16'(q_edge[k]), q_addr[k], q_wr[k], q_wdata[k]};
                exp_t = {16'(2*k), AW'(k % D), (k < D), 8'hA5 ^ W'(k % D)};
                vectors++;
                if (got !== exp_t) begin
                    miscompares++;
                    $display("FAIL clean_req_%0d: got %h required %h", k, got, exp_t);
                end
            end
        end
        vectors++;
        if ({pass, busy, valid, timeout, err_count} !== {4'b1000, 5'd0}) begin
            miscompares++;
            $display("FAIL clean_status: pass/busy/valid/timeout/err got %b required 100000000",
                     {pass, busy, valid, timeout, err_count});
        end
        $display("clean sweep seed=a5: done_edge=%0d reqs=%0d pass=%0d err=%0d",
                 done_edge, q_edge.size(), pass, err_count);
    endtask

    task automatic test_flip_bit();
        clear_faults();
        xor_mask[5] = 8'h01;
        do_sweep(8'hA5, -1, -1);
        vectors++;
        if ({done_edge, 32'(err_count), 32'(first_fail_addr), 32'(pass)} !== {32'(4*D), 32'd1, 32'd5, 32'd0}) begin
            miscompares++;
            $display("FAIL flip_bit0_loc5: edge=%0d err=%0d ffa=%0d pass=%0d required edge=%0d err=1 ffa=5 pass=0",
                     done_edge, err_count, first_fail_addr, pass, 4*D);
        end
        $display("flip bit0@5: err=%0d ffa=%0d pass=%0d", err_count, first_fail_addr, pass);
    endtask

    task automatic test_stuck_bit7();
        clear_faults();
        and_mask[3] = 8'h7F;
        and_mask[9] = 8'h7F;
        do_sweep(8'hFF, -1, -1);
        vectors++;
        if ({done_edge, 32'(err_count), 32'(first_fail_addr), 32'(pass)} !== {32'(4*D), 32'd2, 32'd3, 32'd0}) begin
            miscompares++;
            $display("FAIL stuck_bit7: edge=%0d err=%0d ffa=%0d pass=%0d required edge=%0d err=2 ffa=3 pass=0",
                     done_edge, err_count, first_fail_addr, pass, 4*D);
        end
        $display("stuck bit7@3,9 seed=ff: err=%0d ffa=%0d pass=%0d", err_count, first_fail_addr, pass);
    endtask

    task automatic test_random();
        logic [W-1:0] s;
        logic [28:0]  got, exp_t;
        int errs, first;
        for (int it = 0; it < 5; it++) begin
            clear_faults();
            s = W'($urandom);
            for (int a = 0; a < D; a++) begin
                if ($urandom_range(0, 3) == 0) xor_mask[a] = W'($urandom_range(1, 255));
                if ($urandom_range(0, 7) == 0) and_mask[a] = W'($urandom);
            end
            model_sweep(s, errs, first);
            do_sweep(s, -1, -1);
            vectors++;
            if ({done_edge, 32'(err_count), 32'(first_fail_addr), 32'(pass)} !==
                {32'(4*D), 32'(errs), 32'(first), 32'(errs == 0)}) begin
                miscompares++;
                $display("FAIL random_%0d: edge=%0d err=%0d ffa=%0d pass=%0d required edge=%0d err=%0d ffa=%0d pass=%0d",
                         it, done_edge, err_count, first_fail_addr, pass, 4*D, errs, first, errs == 0);
            end
            for (int k = 0; k < q_edge.size() && k < 2*D; k++) begin
                got   = {16'(q_edge[k]), q_addr[k], q_wr[k], q_wdata[k]};
                exp_t = {16'(2*k), AW'(k % D), (k < D), s ^ W'(k % D)};
                vectors++;
                if (got !== exp_t) begin
                    miscompares++;
                    $display("FAIL random_%0d_req_%0d: got %h required %h", it, k, got, exp_t);
                end
            end
            $display("random sweep %0d seed=%h: err=%0d (model %0d) ffa=%0d (model %0d) pass=%0d",
                     it, s, err_count, errs, first_fail_addr, first, pass);
        end
    endtask

    task automatic test_busy_start();
        logic [28:0] got, exp_t;
        clear_faults();
        do_sweep(8'hA5, 10, -1);
        vectors++;
        if ({done_edge, 32'(pass), 32'(q_edge.size())} !== {32'(4*D), 32'd1, 32'(2*D)}) begin
            miscompares++;
            $display("FAIL busy_start: edge=%0d pass=%0d reqs=%0d required edge=%0d pass=1 reqs=%0d",
                     done_edge, pass, q_edge.size(), 4*D, 2*D);
        end
        for (int k = 0; k < q_edge.size() && k < 2*D; k++) begin
            got   = {16'(q_edge[k]), q_addr[k], q_wr[k], q_wdata[k]};
            exp_t = {16'(2*k), AW'(k % D), (k < D), 8'hA5 ^ W'(k % D)};
            vectors++;
            if (got !== exp_t) begin
                miscompares++;
                $display("FAIL busy_start_req_%0d: got %h required %h", k, got, exp_t);
            end
        end
        $display("start pulse at edge 10 while busy: done_edge=%0d pass=%0d", done_edge, pass);
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        clear_faults();
        do_sweep(8'h3C, -1, 20);
        vectors++;
        if ({valid, wr_rd, addr} !== {2'b11, AW'(10)}) begin
            miscompares++;
            $display("FAIL mid_pre_reset: valid/wr_rd/addr got %b required 111010", {valid, wr_rd, addr});
        end
        #2 rst = 1'b1;
        #1;
        got = 32'({valid, wr_rd, addr, wdata, busy, done, pass, timeout, err_count, first_fail_addr});
        vectors++;
        if (got !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: outputs=%h required 0", got);
        end
        $display("reset at edge 20: outputs=%h", got);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({valid, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL post_reset_idle_%0d: valid/busy got %b required 00", c, {valid, busy});
            end
        end
        do_sweep(8'h5A, -1, -1);
        vectors++;
        if ({done_edge, 32'(pass), 32'(err_count)} !== {32'(4*D), 32'd1, 32'd0}) begin
            miscompares++;
            $display("FAIL post_reset_sweep: edge=%0d pass=%0d err=%0d required edge=%0d pass=1 err=0",
                     done_edge, pass, err_count, 4*D);
        end
        $display("sweep after reset: done_edge=%0d pass=%0d", done_edge, pass);
    endtask

`ifdef MEM_INITIATOR_TIMEOUT_EN
    task automatic test_timeout();
        clear_faults();
        ready_en = 1'b0;
        do_sweep(8'h77, -1, -1);
        vectors++;
        if ({done_edge, 32'(timeout), 32'(done), 32'(pass), 32'(q_edge.size())} !==
            {32'(TO + 1), 32'd1, 32'd1, 32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL timeout: edge=%0d timeout=%0d done=%0d pass=%0d reqs=%0d required edge=%0d 1 1 0 1",
                     done_edge, timeout, done, pass, q_edge.size(), TO + 1);
        end
        $display("no ready: done_edge=%0d timeout=%0d pass=%0d", done_edge, timeout, pass);
        ready_en = 1'b1;
    endtask
`else
    task automatic test_timeout();
        clear_faults();
        ready_en = 1'b0;
        do_sweep(8'h77, -1, 60);
        vectors++;
        if ({done_edge, 32'(busy), 32'(timeout), 32'(q_edge.size())} !== {-32'sd1, 32'd1, 32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL no_timeout_wait: edge=%0d busy=%0d timeout=%0d reqs=%0d required -1 1 0 1",
                     done_edge, busy, timeout, q_edge.size());
        end
        $display("no ready, no timeout: busy=%0d timeout=%0d reqs=%0d", busy, timeout, q_edge.size());
        ready_en = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_clean_sweep();
        test_flip_bit();
        test_stuck_bit7();
        test_random();
        test_busy_start();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
